// File: rtl/dec_fpr_bank_ctl.sv
`default_nettype none
// ============================================================================
// Module   : dec_fpr_bank_ctl
// Brief    : Multi-bank FP register file with bank-copy engine and dirty bits.
//            Optional write-through read bypass: FPR_WR_BYPASS_EN
// Revision : 1.0 - initial release
// ============================================================================
module dec_fpr_bank_ctl #(
   parameter  int FLEN   = 32,
   parameter  int NBANKS = 2,
   parameter  int NRD    = 6,
   parameter  int NWR    = 2,
   localparam int BW     = (NBANKS > 1) ? $clog2(NBANKS) : 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NRD-1:0]        i_rden,
   input  logic [NRD*5-1:0]      i_raddr,
   output logic [NRD*FLEN-1:0]   o_rd,
   input  logic [NWR-1:0]        i_wen,
   input  logic [NWR*5-1:0]      i_waddr,
   input  logic [NWR*FLEN-1:0]   i_wd,
   input  logic                  i_bank_wen,
   input  logic [BW-1:0]         i_bank_id,
   output logic [BW-1:0]         o_act_bank,
   input  logic                  i_copy_req,
   input  logic [BW-1:0]         i_copy_src,
   input  logic [BW-1:0]         i_copy_dst,
   output logic                  o_copy_busy,
   output logic                  o_copy_done,
   output logic                  o_wr_drop,
   output logic [NBANKS-1:0]     o_dirty,
   input  logic [NBANKS-1:0]     i_dirty_clr
);

   localparam logic [BW:0] c_nbanks = (BW+1)'(NBANKS);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_COPY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   logic [FLEN-1:0]   r_regs [NBANKS][32];
   state_t            r_state;
   logic [4:0]        r_idx;
   logic [BW-1:0]     r_src;
   logic [BW-1:0]     r_dst;
   logic              r_copy_busy;
   logic              r_copy_done;
   logic              r_wr_drop;
   logic [BW-1:0]     r_act_bank;
   logic [NBANKS-1:0] r_dirty;

   logic [NWR-1:0]    w_wr_req;
   logic [NWR-1:0]    w_wr_acc;
   logic [NBANKS-1:0] w_dirty_set;
   logic              w_src_ok;
   logic              w_dst_ok;
   logic              w_bank_ok;

   assign w_src_ok  = {1'b0, i_copy_src} < c_nbanks;
   assign w_dst_ok  = {1'b0, i_copy_dst} < c_nbanks;
   assign w_bank_ok = {1'b0, i_bank_id}  < c_nbanks;

   // Writes to f0 are not requests at all; the rest are refused while copying.
   always_comb begin
      w_wr_req = '0;
      w_wr_acc = '0;
      for (int q = 0; q < NWR; q++) begin
         w_wr_req[q] = i_wen[q] && (i_waddr[5*q +: 5] != 5'd0);
         w_wr_acc[q] = w_wr_req[q] && !r_copy_busy;
      end
   end

   always_comb begin
      w_dirty_set = '0;
      if (|w_wr_acc)
         w_dirty_set[r_act_bank] = 1'b1;
      if (r_state == S_COPY)
         w_dirty_set[r_dst] = 1'b1;
   end

   generate
      for (genvar p = 0; p < NRD; p++) begin : g_rd
         logic [4:0]      w_ra;
         logic [FLEN-1:0] w_rdata;
         assign w_ra = i_raddr[5*p +: 5];
         always_comb begin
            w_rdata = r_regs[r_act_bank][w_ra];
`ifdef FPR_WR_BYPASS_EN
            for (int q = 0; q < NWR; q++) begin
               if (w_wr_acc[q] && (i_waddr[5*q +: 5] == w_ra))
                  w_rdata = i_wd[FLEN*q +: FLEN];
            end
`endif
         end
         assign o_rd[FLEN*p +: FLEN] = (rst || !i_rden[p] || (w_ra == 5'd0)) ? '0 : w_rdata;
      end
   endgenerate

   // Later ports overwrite earlier ones, so the highest-index writer wins.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int b = 0; b < NBANKS; b++)
            for (int r = 0; r < 32; r++)
               r_regs[b][r] <= '0;
      end else begin
         if (r_state == S_COPY)
            r_regs[r_dst][r_idx] <= r_regs[r_src][r_idx];
         for (int q = 0; q < NWR; q++)
            if (w_wr_acc[q])
               r_regs[r_act_bank][i_waddr[5*q +: 5]] <= i_wd[FLEN*q +: FLEN];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_idx       <= 5'd0;
         r_src       <= '0;
         r_dst       <= '0;
         r_copy_busy <= 1'b0;
         r_copy_done <= 1'b0;
      end else begin
         r_copy_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (i_copy_req && w_src_ok && w_dst_ok) begin
                  r_src       <= i_copy_src;
                  r_dst       <= i_copy_dst;
                  r_copy_busy <= 1'b1;
                  if (i_copy_src == i_copy_dst) begin
                     r_state     <= S_DONE;
                     r_copy_done <= 1'b1;
                  end else begin
                     r_state <= S_COPY;
                     r_idx   <= 5'd1;
                  end
               end
            end
            S_COPY: begin
               r_idx <= r_idx + 5'd1;
               if (r_idx == 5'd31) begin
                  r_state     <= S_DONE;
                  r_copy_done <= 1'b1;
               end
            end
            S_DONE: begin
               r_state     <= S_IDLE;
               r_copy_busy <= 1'b0;
            end
            default: begin
               r_state     <= S_IDLE;
               r_copy_busy <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_act_bank <= '0;
         r_dirty    <= '0;
         r_wr_drop  <= 1'b0;
      end else begin
         if (i_bank_wen && !r_copy_busy && w_bank_ok)
            r_act_bank <= i_bank_id;
         r_dirty   <= (r_dirty & ~i_dirty_clr) | w_dirty_set;
         r_wr_drop <= r_copy_busy && (|w_wr_req);
      end
   end

   assign o_act_bank  = r_act_bank;
   assign o_copy_busy = r_copy_busy;
   assign o_copy_done = r_copy_done;
   assign o_wr_drop   = r_wr_drop;
   assign o_dirty     = r_dirty;

endmodule
`default_nettype wire

// File: tb/tb_dec_fpr_bank_ctl.sv
`default_nettype none
// ============================================================================
// Module   : tb_dec_fpr_bank_ctl
// Brief    : Directed self-checking bench for dec_fpr_bank_ctl (default params).
// Revision : 1.0 - initial release
// ============================================================================
module tb_dec_fpr_bank_ctl;

   localparam int FLEN = 32;
   localparam int NRD  = 6;
   localparam int NWR  = 2;
   localparam int NB   = 2;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [NRD-1:0]    rden = '1;
   logic [NRD*5-1:0]  raddr = '0;
   logic [NRD*FLEN-1:0] rd;
   logic [NWR-1:0]    wen = '0;
   logic [NWR*5-1:0]  waddr = '0;
   logic [NWR*FLEN-1:0] wd = '0;
   logic              bank_wen = 1'b0;
   logic [0:0]        bank_id = '0;
   logic [0:0]        act_bank;
   logic              copy_req = 1'b0;
   logic [0:0]        copy_src = '0;
   logic [0:0]        copy_dst = '0;
   logic              copy_busy, copy_done, wr_drop;
   logic [NB-1:0]     dirty;
   logic [NB-1:0]     dirty_clr = '0;

   int n_vec = 0;
   int n_err = 0;

   dec_fpr_bank_ctl #(.FLEN(FLEN), .NBANKS(NB), .NRD(NRD), .NWR(NWR)) dut (
      .clk(clk), .rst(rst),
      .i_rden(rden), .i_raddr(raddr), .o_rd(rd),
      .i_wen(wen), .i_waddr(waddr), .i_wd(wd),
      .i_bank_wen(bank_wen), .i_bank_id(bank_id), .o_act_bank(act_bank),
      .i_copy_req(copy_req), .i_copy_src(copy_src), .i_copy_dst(copy_dst),
      .o_copy_busy(copy_busy), .o_copy_done(copy_done), .o_wr_drop(wr_drop),
      .o_dirty(dirty), .i_dirty_clr(dirty_clr)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rd_chk(input string tag, input int p, input logic [4:0] a, input logic [31:0] exp);
      raddr[5*p +: 5] = a;
      #1;
      check(tag, 64'(rd[FLEN*p +: FLEN]), 64'(exp));
   endtask

   task automatic wr1(input int p, input logic [4:0] a, input logic [31:0] d);
      wen[p]             = 1'b1;
      waddr[5*p +: 5]    = a;
      wd[FLEN*p +: FLEN] = d;
   endtask

   task automatic set_bank(input logic [0:0] b);
      bank_wen = 1'b1;
      bank_id  = b;
      tick();
      bank_wen = 1'b0;
   endtask

   initial begin
      // reset state
      raddr = {NRD{5'd5}};
      tick();
      check("rd_in_reset", 64'(rd), 64'd0);
      rst = 1'b0;
      tick();
      check("busy_rst", 64'(copy_busy), 64'd0);
      check("done_rst", 64'(copy_done), 64'd0);
      check("drop_rst", 64'(wr_drop), 64'd0);
      check("dirty_rst", 64'(dirty), 64'd0);
      check("bank_rst", 64'(act_bank), 64'd0);

      // test 1
      for (int a = 0; a < 32; a++) begin
         raddr = {NRD{5'(a)}};
         #1;
         check("rd_all_zero", 64'(rd), 64'd0);
      end
      wr1(0, 5'd5, 32'hDEADBEEF);
      tick();
      wen = '0;
      rd_chk("f5_port3", 3, 5'd5, 32'hDEADBEEF);
      check("dirty_f5", 64'(dirty), 64'd1);
      rden[3] = 1'b0;
      rd_chk("rden_off", 3, 5'd5, 32'h0);
      rden[3] = 1'b1;

      // test 2: same-address collision, then disjoint pair
      wr1(0, 5'd7, 32'h1111);
      wr1(1, 5'd7, 32'h2222);
      tick();
      wen = '0;
      rd_chk("f7_collide", 1, 5'd7, 32'h2222);
      wr1(0, 5'd8, 32'h8888);
      wr1(1, 5'd9, 32'h9999);
      tick();
      wen = '0;
      rd_chk("f8_pair", 0, 5'd8, 32'h8888);
      rd_chk("f9_pair", 5, 5'd9, 32'h9999);

      // test 3/4: fill, copy 0->1 with a dropped write and bank switch inside
      for (int i = 1; i < 32; i++) begin
         wr1(0, 5'(i), 32'(i));
         tick();
      end
      wen = '0;
      copy_req = 1'b1; copy_src = 1'b0; copy_dst = 1'b1;
      for (int c = 1; c <= 32; c++) begin
         tick();
         copy_req = 1'b0;
         if (copy_busy !== 1'b1) check("busy_during", 64'(copy_busy), 64'd1);
         if (c == 1 || c == 31 || c == 32) check("done_cyc", 64'(copy_done), 64'(c == 32));
         if (c == 5) begin
            wr1(0, 5'd3, 32'hFFFF);
            bank_wen = 1'b1; bank_id = 1'b1;
         end
         if (c == 6) begin
            wen = '0; bank_wen = 1'b0;
            check("drop_pulse", 64'(wr_drop), 64'd1);
            check("bank_hold", 64'(act_bank), 64'd0);
         end
         if (c == 7) check("drop_once", 64'(wr_drop), 64'd0);
         if (c == 10) rd_chk("rd_in_copy", 2, 5'd10, 32'd10);
      end
      tick();
      check("busy_end", 64'(copy_busy), 64'd0);
      check("done_end", 64'(copy_done), 64'd0);
      rd_chk("f3_dropped", 0, 5'd3, 32'd3);
      set_bank(1'b1);
      check("bank_sw", 64'(act_bank), 64'd1);
      for (int i = 1; i < 32; i++)
         rd_chk("bank1_copy", i % NRD, 5'(i), 32'(i));
      check("dirty_copy", 64'(dirty), 64'd3);
      dirty_clr = 2'b01;
      tick();
      dirty_clr = '0;
      check("dirty_clr0", 64'(dirty), 64'd2);
      dirty_clr = 2'b10;
      tick();
      dirty_clr = '0;
      check("dirty_clr1", 64'(dirty), 64'd0);

      // test 5: src==dst, then reset mid-copy
      copy_req = 1'b1; copy_src = 1'b1; copy_dst = 1'b1;
      tick();
      copy_req = 1'b0;
      check("same_done", 64'(copy_done), 64'd1);
      check("same_busy", 64'(copy_busy), 64'd1);
      tick();
      check("same_idle", 64'(copy_busy), 64'd0);
      check("same_dirty", 64'(dirty), 64'd0);
      rd_chk("same_f4", 4, 5'd4, 32'd4);
      copy_req = 1'b1; copy_src = 1'b0; copy_dst = 1'b1;
      tick();
      copy_req = 1'b0;
      for (int k = 0; k < 9; k++) tick();
      rst = 1'b1;
      #1;
      check("rst_busy", 64'(copy_busy), 64'd0);
      tick();
      rst = 1'b0;
      tick();
      check("rst_bank", 64'(act_bank), 64'd0);
      check("rst_dirty", 64'(dirty), 64'd0);
      for (int i = 1; i < 32; i++) rd_chk("rst_b0", i % NRD, 5'(i), 32'd0);
      set_bank(1'b1);
      for (int i = 1; i < 32; i++) rd_chk("rst_b1", i % NRD, 5'(i), 32'd0);
      set_bank(1'b0);

      // test 6: same-cycle write/read of f9
      wr1(0, 5'd9, 32'h12345678);
      tick();
      wr1(1, 5'd9, 32'hA5A5A5A5);
      wen[0] = 1'b0;
`ifdef FPR_WR_BYPASS_EN
      rd_chk("bypass_f9", 2, 5'd9, 32'hA5A5A5A5);
`else
      rd_chk("bypass_f9", 2, 5'd9, 32'h12345678);
`endif
      tick();
      wen = '0;
      rd_chk("f9_after", 2, 5'd9, 32'hA5A5A5A5);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
